// File: rtl/dense_mac_pkg.sv
// Shared definitions for the dense MAC scorer: CPU address map, control/status bit
// positions, FSM state encoding and address-width helpers.
package dense_mac_pkg;

  localparam int unsigned AdrW = 18;

  localparam logic [AdrW-1:0] AdrCtrl       = 18'h00000;
  localparam logic [AdrW-1:0] AdrStatus     = 18'h00001;
  localparam logic [AdrW-1:0] AdrResultBase = 18'h00100;
  localparam logic [AdrW-1:0] AdrImageBase  = 18'h01000;
  localparam logic [AdrW-1:0] AdrBiasBase   = 18'h02000;
  localparam logic [AdrW-1:0] AdrWeightBase = 18'h10000;

  localparam int unsigned CtrlStartBit    = 0;
  localparam int unsigned CtrlClearBit    = 1;
  localparam int unsigned StatusBusyBit   = 0;
  localparam int unsigned StatusDoneBit   = 1;
  localparam int unsigned StatusArgmaxLsb = 8;

  typedef enum logic [2:0] {
    StIdle,
    StBias,
    StMac,
    StDrain,
    StStore,
    StFin
  } state_e;

  // A depth of 1 still needs a one-bit address.
  function automatic int unsigned addr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic in_window(logic [AdrW-1:0] adr, logic [AdrW-1:0] base,
                                     int unsigned size);
    return (adr >= base) && (32'(adr - base) < size);
  endfunction

endpackage

// File: rtl/mac_sram.sv
// Single-port synchronous RAM with one-cycle read latency; contents are not reset.
module mac_sram
  import dense_mac_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = addr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i && (32'(addr_i) < DEPTH)) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/dense_mac_engine.sv
// Time-multiplexed image-times-weight scorer: one MAC per cycle over RAM-held operands,
// producing NCLASS biased scores plus a running argmax, all readable over the CPU bus.
module dense_mac_engine
  import dense_mac_pkg::*;
#(
  parameter int unsigned NCLASS = 10,
  parameter int unsigned NPIX   = 784,
  parameter int unsigned DW     = 8,
  parameter int unsigned ACCW   = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WR,
  input  logic        RD,
  input  logic [17:0] ADR,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  output logic        BUSY,
  output logic        DONE
);

  localparam int unsigned NWgt  = NCLASS * NPIX;
  localparam int unsigned ImgAw = addr_width(NPIX);
  localparam int unsigned WgtAw = addr_width(NWgt);
  localparam int unsigned ClsAw = addr_width(NCLASS);
  localparam int unsigned PrdW  = 2 * DW + 1;

  state_e            state_q;
  logic              busy_q, done_q;
  logic [ClsAw-1:0]  cls_q, argmax_q;
  logic [ImgAw-1:0]  pix_q;
  logic [WgtAw-1:0]  waddr_q;
  logic [ACCW-1:0]   acc_q, best_q;
  logic [ACCW-1:0]   result_q [NCLASS];
  logic [31:0]       rdata_q, rd_mux;

  // Bus decode
  logic ctrl_wr, start, clr_done;
  logic img_we, wgt_we, bias_we, res_hit;
  logic unused_wdata;

  assign ctrl_wr  = WR && (ADR == AdrCtrl);
  assign start    = ctrl_wr && WDATA[CtrlStartBit] && !busy_q;
  assign clr_done = ctrl_wr && WDATA[CtrlClearBit];
  assign img_we   = WR && !busy_q && in_window(ADR, AdrImageBase, NPIX);
  assign wgt_we   = WR && !busy_q && in_window(ADR, AdrWeightBase, NWgt);
  assign bias_we  = WR && !busy_q && in_window(ADR, AdrBiasBase, NCLASS);
  assign res_hit  = in_window(ADR, AdrResultBase, NCLASS);
  assign unused_wdata = ^WDATA;

  // RAM ports belong to the CPU while idle and to the sequencer while busy.
  logic [ImgAw-1:0] img_addr;
  logic [WgtAw-1:0] wgt_addr;
  logic [ClsAw-1:0] bias_addr;
  logic [DW-1:0]    img_rdata, wgt_rdata, bias_rdata;

  assign img_addr  = busy_q ? pix_q   : ImgAw'(ADR - AdrImageBase);
  assign wgt_addr  = busy_q ? waddr_q : WgtAw'(ADR - AdrWeightBase);
  assign bias_addr = busy_q ? cls_q   : ClsAw'(ADR - AdrBiasBase);

  mac_sram #(.WIDTH(DW), .DEPTH(NPIX)) u_img (
    .clk_i   (CLK),
    .we_i    (img_we),
    .addr_i  (img_addr),
    .wdata_i (WDATA[DW-1:0]),
    .rdata_o (img_rdata)
  );

  mac_sram #(.WIDTH(DW), .DEPTH(NWgt)) u_wgt (
    .clk_i   (CLK),
    .we_i    (wgt_we),
    .addr_i  (wgt_addr),
    .wdata_i (WDATA[DW-1:0]),
    .rdata_o (wgt_rdata)
  );

  mac_sram #(.WIDTH(DW), .DEPTH(NCLASS)) u_bias (
    .clk_i   (CLK),
    .we_i    (bias_we),
    .addr_i  (bias_addr),
    .wdata_i (WDATA[DW-1:0]),
    .rdata_o (bias_rdata)
  );

  // Pixel is unsigned, weight signed; both widened so the product cannot overflow.
  logic signed [PrdW-1:0] pix_s, wgt_s, prod;
  logic [ACCW-1:0]        prod_ext, bias_ext;

  assign pix_s    = $signed({{DW{1'b0}}, 1'b0, img_rdata});
  assign wgt_s    = $signed({{(DW + 1){wgt_rdata[DW-1]}}, wgt_rdata});
  assign prod     = pix_s * wgt_s;
  assign prod_ext = ACCW'(prod);
  assign bias_ext = ACCW'($signed(bias_rdata));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cls_q    <= '0;
      argmax_q <= '0;
      pix_q    <= '0;
      waddr_q  <= '0;
      acc_q    <= '0;
      best_q   <= '0;
      for (int unsigned k = 0; k < NCLASS; k++) result_q[k] <= '0;
    end else begin
      if (clr_done) done_q <= 1'b0;
      if (start) begin
        state_q  <= StBias;
        busy_q   <= 1'b1;
        done_q   <= 1'b0;
        cls_q    <= '0;
        argmax_q <= '0;
        pix_q    <= '0;
        waddr_q  <= '0;
        for (int unsigned k = 0; k < NCLASS; k++) result_q[k] <= '0;
      end else begin
        case (state_q)
          StBias: begin
            pix_q   <= '0;
            state_q <= StMac;
          end
          StMac: begin
            // Operands arrive one cycle after their read, so slot 0 loads the bias.
            acc_q   <= (pix_q == '0) ? bias_ext : acc_q + prod_ext;
            waddr_q <= waddr_q + 1'b1;
            if (32'(pix_q) == NPIX - 1) begin
              state_q <= StDrain;
            end else begin
              pix_q <= pix_q + 1'b1;
            end
          end
          StDrain: begin
            acc_q   <= acc_q + prod_ext;
            state_q <= StStore;
          end
          StStore: begin
            result_q[cls_q] <= acc_q;
            if ((cls_q == '0) || ($signed(acc_q) > $signed(best_q))) begin
              best_q   <= acc_q;
              argmax_q <= cls_q;
            end
            if (32'(cls_q) == NCLASS - 1) begin
              state_q <= StFin;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cls_q   <= cls_q + 1'b1;
              state_q <= StBias;
            end
          end
          StFin:   state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (ADR == AdrStatus) begin
      rd_mux[StatusBusyBit]             = busy_q;
      rd_mux[StatusDoneBit]             = done_q;
      rd_mux[StatusArgmaxLsb +: 8]      = 8'(argmax_q);
    end else if (res_hit) begin
      rd_mux = 32'($signed(result_q[ClsAw'(ADR - AdrResultBase)]));
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rdata_q <= '0;
    end else if (RD) begin
      rdata_q <= rd_mux;
    end
  end

  assign RDATA = rdata_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_dense_mac_engine.sv
// Directed bench: a 3-class/4-pixel instance for timing and protocol cases and a
// default-sized instance for the extreme-value arithmetic case.
module tb_dense_mac_engine;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        wr    [2];
  logic        rd    [2];
  logic [17:0] adr   [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        busy  [2];
  logic        done  [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dense_mac_engine #(.NCLASS(3), .NPIX(4), .DW(8), .ACCW(32)) u_small (
    .CLK   (clk),
    .RESET (rst[0]),
    .WR    (wr[0]),
    .RD    (rd[0]),
    .ADR   (adr[0]),
    .WDATA (wdata[0]),
    .RDATA (rdata[0]),
    .BUSY  (busy[0]),
    .DONE  (done[0])
  );

  dense_mac_engine u_big (
    .CLK   (clk),
    .RESET (rst[1]),
    .WR    (wr[1]),
    .RD    (rd[1]),
    .ADR   (adr[1]),
    .WDATA (wdata[1]),
    .RDATA (rdata[1]),
    .BUSY  (busy[1]),
    .DONE  (done[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input int d, input logic [17:0] a, input logic [31:0] v);
    @(negedge clk);
    wr[d] = 1'b1; adr[d] = a; wdata[d] = v;
    @(negedge clk);
    wr[d] = 1'b0;
  endtask

  task automatic bus_read(input int d, input logic [17:0] a, output logic [31:0] v);
    @(negedge clk);
    rd[d] = 1'b1; adr[d] = a;
    @(negedge clk);
    rd[d] = 1'b0;
    v = rdata[d];
  endtask

  // Returns at the negedge after the START edge.
  task automatic run_start(input int d, input string tag);
    bus_write(d, 18'h00000, 32'h1);
    check({tag, "_busy_rise"}, 32'(busy[d]), 32'h1);
    check({tag, "_done_clr"}, 32'(done[d]), 32'h0);
  endtask

  // cyc counts edges after START until DONE is seen; busy_cyc counts cycles with BUSY=1.
  task automatic wait_done(input int d, input int bound, input string tag,
                           output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = busy[d] ? 1 : 0;
    while (!done[d] && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (busy[d]) busy_cyc++;
    end
    check({tag, "_done_seen"}, 32'(done[d]), 32'h1);
  endtask

  task automatic load_small(input int w1v, input int b1v, input int w2last, input int b2v);
    int img [4] = '{1, 2, 3, 4};
    for (int i = 0; i < 4; i++) bus_write(0, 18'h01000 + 18'(i), 32'(img[i]));
    for (int i = 0; i < 4; i++) begin
      bus_write(0, 18'h10000 + 18'(i), 32'(1));
      bus_write(0, 18'h10004 + 18'(i), 32'(w1v));
      bus_write(0, 18'h10008 + 18'(i), (i == 3) ? 32'(w2last) : 32'h0);
    end
    bus_write(0, 18'h02000, 32'(5));
    bus_write(0, 18'h02001, 32'(b1v));
    bus_write(0, 18'h02002, 32'(b2v));
  endtask

  task automatic check_small(input string tag, input logic [31:0] r0, input logic [31:0] r1,
                             input logic [31:0] r2, input logic [31:0] st);
    logic [31:0] v;
    bus_read(0, 18'h00100, v); check({tag, "_result0"}, v, r0);
    bus_read(0, 18'h00101, v); check({tag, "_result1"}, v, r1);
    bus_read(0, 18'h00102, v); check({tag, "_result2"}, v, r2);
    bus_read(0, 18'h00001, v); check({tag, "_status"}, v, st);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int cyc, bcyc, extra_busy;
    int exp3;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; wr[d] = 1'b0; rd[d] = 1'b0; adr[d] = '0; wdata[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Reset state
    check("rst_rdata", rdata[0], 32'h0);
    check("rst_busy", 32'(busy[0]), 32'h0);
    check("rst_done", 32'(done[0]), 32'h0);
    check_small("rst", 32'h0, 32'h0, 32'h0, 32'h0);

    // Basic run: scores 15, -10, 24 -> argmax 2
    load_small(-1, 0, 1, 20);
    run_start(0, "basic");
    wait_done(0, 200, "basic", cyc, bcyc);
    check("basic_latency", 32'(cyc), 32'd21);
    check("basic_busy_cycles", 32'(bcyc), 32'd21);
    check("basic_busy_fall", 32'(busy[0]), 32'h0);
    check_small("basic", 32'd15, 32'hFFFF_FFF6, 32'd24, 32'h0000_0202);

    // Write-only and unmapped reads return zero (previous RDATA was non-zero)
    bus_read(0, 18'h01000, v); check("unmapped_image", v, 32'h0);
    bus_read(0, 18'h00001, v); check("status_reload", v, 32'h0000_0202);
    bus_read(0, 18'h3FFFF, v); check("unmapped_top", v, 32'h0);

    // Busy protection: RAM write and second START dropped
    run_start(0, "prot");
    bus_write(0, 18'h10000, 32'd99);
    bus_write(0, 18'h00000, 32'h1);
    wait_done(0, 200, "prot", cyc, bcyc);
    extra_busy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy[0] || !done[0]) extra_busy++;
    end
    check("prot_single_done", 32'(extra_busy), 32'h0);
    check_small("prot", 32'd15, 32'hFFFF_FFF6, 32'd24, 32'h0000_0202);
    bus_write(0, 18'h00000, 32'h2);
    bus_read(0, 18'h00001, v); check("prot_done_cleared", v, 32'h0000_0200);

    // Reset at cycle 10 of a run, then restart from retained RAM
    run_start(0, "rstmid");
    repeat (9) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("rstmid_busy", 32'(busy[0]), 32'h0);
    check("rstmid_done", 32'(done[0]), 32'h0);
    repeat (5) @(negedge clk);
    check("rstmid_stays_idle", 32'(busy[0]), 32'h0);
    check_small("rstmid", 32'h0, 32'h0, 32'h0, 32'h0);
    run_start(0, "rerun");
    wait_done(0, 200, "rerun", cyc, bcyc);
    check("rerun_latency", 32'(cyc), 32'd21);
    check_small("rerun", 32'd15, 32'hFFFF_FFF6, 32'd24, 32'h0000_0202);

    // Tie between classes 0 and 1 keeps the lower index
    load_small(1, 5, 0, 0);
    run_start(0, "tie");
    wait_done(0, 200, "tie", cyc, bcyc);
    check_small("tie", 32'd15, 32'd15, 32'd0, 32'h0000_0002);

    // Extreme values at default size: 784 * 255 * -128 - 128
    for (int i = 0; i < 784; i++) bus_write(1, 18'h01000 + 18'(i), 32'd255);
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 784; i++) begin
        bus_write(1, 18'h10000 + 18'(k * 784 + i), (k == 3) ? 32'h80 : 32'h0);
      end
      bus_write(1, 18'h02000 + 18'(k), (k == 3) ? 32'h80 : 32'h0);
    end
    run_start(1, "ext");
    wait_done(1, 10000, "ext", cyc, bcyc);
    check("ext_latency", 32'(cyc), 32'd7870);
    exp3 = 784 * 255 * (-128) - 128;
    bus_read(1, 18'h00103, v); check("ext_result3", v, 32'(exp3));
    bus_read(1, 18'h00100, v); check("ext_result0", v, 32'h0);
    bus_read(1, 18'h00001, v); check("ext_status", v, 32'h0000_0002);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
